// File: rtl/enc_dec_op_sequencer.sv
// Runs one encoder/decoder operation per CTRL write: encode, decode, or the full
// encode -> noise -> decode chain over req/ack handshakes, with a per-request timeout.
module enc_dec_op_sequencer #(
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int TO_CNT_W       = 5
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    input  logic [1:0]            ctrl,
    input  logic [1:0]            width_sel,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [DATA_WIDTH-1:0] noise,
    output logic                  enc_req,
    output logic [DATA_WIDTH-1:0] enc_word,
    input  logic                  enc_ack,
    input  logic [DATA_WIDTH-1:0] enc_result,
    output logic                  dec_req,
    output logic [DATA_WIDTH-1:0] dec_word,
    input  logic                  dec_ack,
    input  logic [DATA_WIDTH-1:0] dec_result,
    input  logic [1:0]            dec_nerr,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [1:0]            num_of_errors,
    output logic                  operation_done,
    output logic                  op_error,
    output logic                  busy
);

    // state    | meaning
    // IDLE     | waiting for start
    // ENC_REQ  | encoder request outstanding
    // DEC_REQ  | decoder request outstanding
    // DONE     | success, done pulse issued on exit
    // FAIL     | illegal op or timeout, done + op_error pulse issued on exit
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ENC  = 3'd1;
    localparam logic [2:0] S_DEC  = 3'd2;
    localparam logic [2:0] S_DONE = 3'd3;
    localparam logic [2:0] S_FAIL = 3'd4;

    localparam logic [1:0] OP_DEC  = 2'b01;
    localparam logic [1:0] OP_FULL = 2'b10;
    localparam logic [1:0] OP_ILL  = 2'b11;
    localparam logic [1:0] WS_ILL  = 2'b11;

    localparam logic [TO_CNT_W-1:0] TO_LAST = TO_CNT_W'(TIMEOUT_CYCLES - 1);

    logic [2:0]            state;
    logic [1:0]            op_q;
    logic [1:0]            ws_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] noise_q;
    logic [DATA_WIDTH-1:0] cw_q;
    logic [TO_CNT_W-1:0]   to_cnt;
    logic [DATA_WIDTH-1:0] cmask;
    logic [DATA_WIDTH-1:0] imask;
    logic                  to_hit;

    function automatic logic [DATA_WIDTH-1:0] low_ones(input int n);
        logic [DATA_WIDTH-1:0] m;
        m = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            m[i] = (i < n);
        end
        return m;
    endfunction

    always_comb begin
        cmask = '0;
        imask = '0;
        case (ws_q)
            2'b00: begin cmask = low_ones(8);  imask = low_ones(4);  end
            2'b01: begin cmask = low_ones(16); imask = low_ones(11); end
            2'b10: begin cmask = low_ones(32); imask = low_ones(26); end
            default: begin cmask = '0; imask = '0; end
        endcase
    end

    // Request outputs decode straight from state so reset removes them asynchronously.
    assign enc_req  = (state == S_ENC);
    assign dec_req  = (state == S_DEC);
    assign busy     = (state != S_IDLE);
    assign enc_word = enc_req ? (data_q & imask) : '0;
    assign dec_word = dec_req ? ((op_q == OP_FULL) ? cw_q : (data_q & cmask)) : '0;
    assign to_hit   = (to_cnt == TO_LAST);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state          <= S_IDLE;
            op_q           <= '0;
            ws_q           <= '0;
            data_q         <= '0;
            noise_q        <= '0;
            cw_q           <= '0;
            to_cnt         <= '0;
            data_out       <= '0;
            num_of_errors  <= '0;
            operation_done <= 1'b0;
            op_error       <= 1'b0;
        end else begin
            operation_done <= 1'b0;
            op_error       <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_q    <= ctrl;
                        ws_q    <= width_sel;
                        data_q  <= data_in;
                        noise_q <= noise;
                        to_cnt  <= '0;
                        if (ctrl == OP_ILL || width_sel == WS_ILL) begin
                            state <= S_FAIL;
                        end else if (ctrl == OP_DEC) begin
                            state <= S_DEC;
                        end else begin
                            state <= S_ENC;
                        end
                    end
                end
                S_ENC: begin
                    // ack is checked before the terminal count so a last-cycle ack still succeeds
                    if (enc_ack) begin
                        if (op_q == OP_FULL) begin
                            cw_q   <= (enc_result ^ noise_q) & cmask;
                            to_cnt <= '0;
                            state  <= S_DEC;
                        end else begin
                            data_out      <= enc_result & cmask;
                            num_of_errors <= 2'd0;
                            state         <= S_DONE;
                        end
                    end else if (to_hit) begin
                        state <= S_FAIL;
                    end else begin
                        to_cnt <= to_cnt + TO_CNT_W'(1);
                    end
                end
                S_DEC: begin
                    if (dec_ack) begin
                        data_out      <= dec_result & imask;
                        num_of_errors <= dec_nerr;
                        state         <= S_DONE;
                    end else if (to_hit) begin
                        state <= S_FAIL;
                    end else begin
                        to_cnt <= to_cnt + TO_CNT_W'(1);
                    end
                end
                S_DONE: begin
                    operation_done <= 1'b1;
                    state          <= S_IDLE;
                end
                S_FAIL: begin
                    operation_done <= 1'b1;
                    op_error       <= 1'b1;
                    num_of_errors  <= 2'd3;
                    state          <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_enc_dec_op_sequencer.sv
// Directed bench for enc_dec_op_sequencer: encoder/decoder stubs with programmable
// ack delay, and a scoreboard of expected completions checked on each done pulse.
module tb_enc_dec_op_sequencer;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  ctrl = '0;
    logic [1:0]  width_sel = '0;
    logic [31:0] data_in = '0;
    logic [31:0] noise = '0;
    logic        enc_req;
    logic [31:0] enc_word;
    logic        enc_ack;
    logic [31:0] enc_result = '0;
    logic        dec_req;
    logic [31:0] dec_word;
    logic        dec_ack;
    logic [31:0] dec_result = '0;
    logic [1:0]  dec_nerr = '0;
    logic [31:0] data_out;
    logic [1:0]  num_of_errors;
    logic        operation_done;
    logic        op_error;
    logic        busy;

    enc_dec_op_sequencer #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(16), .TO_CNT_W(5)) dut (
        .clk(clk), .rstn(rstn), .start(start), .ctrl(ctrl), .width_sel(width_sel),
        .data_in(data_in), .noise(noise),
        .enc_req(enc_req), .enc_word(enc_word), .enc_ack(enc_ack), .enc_result(enc_result),
        .dec_req(dec_req), .dec_word(dec_word), .dec_ack(dec_ack), .dec_result(dec_result),
        .dec_nerr(dec_nerr), .data_out(data_out), .num_of_errors(num_of_errors),
        .operation_done(operation_done), .op_error(op_error), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Stubs: ack once the request has been high for enc_dly/dec_dly earlier cycles.
    int enc_dly = 0, dec_dly = 0;
    int enc_cyc = 0, dec_cyc = 0;
    always @(posedge clk) begin
        enc_cyc <= enc_req ? enc_cyc + 1 : 0;
        dec_cyc <= dec_req ? dec_cyc + 1 : 0;
    end
    assign enc_ack = enc_req && (enc_cyc == enc_dly);
    assign dec_ack = dec_req && (dec_cyc == dec_dly);

    typedef struct {
        logic [31:0] data;
        logic [1:0]  nerr;
        logic        err;
    } exp_t;
    exp_t sbq[$];

    logic [31:0] exp_enc_word = '0;
    logic [31:0] exp_dec_word = '0;
    logic [31:0] last_data = '0;
    int enc_hi = 0, dec_hi = 0, done_cnt = 0;

    always @(negedge clk) begin
        if (enc_req) begin
            enc_hi++;
            chk("enc_word", enc_word, exp_enc_word);
        end
        if (dec_req) begin
            dec_hi++;
            chk("dec_word", dec_word, exp_dec_word);
        end
        if (op_error && !operation_done) chk("op_error_without_done", 32'(op_error), 32'd0);
        if (operation_done) begin
            exp_t e;
            done_cnt++;
            if (sbq.size() == 0) begin
                chk("unexpected_done", 32'(sbq.size()), 32'd1);
            end else begin
                e = sbq.pop_front();
                chk("data_out", data_out, e.data);
                chk("num_of_errors", 32'(num_of_errors), 32'(e.nerr));
                chk("op_error", 32'(op_error), 32'(e.err));
            end
        end
    end

    task automatic run_op(input logic [1:0] c, input logic [1:0] ws, input logic [31:0] din,
                          input logic [31:0] nz, input logic [31:0] e_res, input int e_dly,
                          input logic [31:0] d_res, input logic [1:0] nerr, input int d_dly,
                          input logic [31:0] x_enc, input logic [31:0] x_dec,
                          input logic [31:0] x_data, input logic [1:0] x_nerr, input logic x_err,
                          input int x_lat, input int x_enc_hi, input int x_dec_hi,
                          input logic dbl);
        exp_t e;
        int lat;
        int done_before;
        @(negedge clk);
        ctrl = c; width_sel = ws; data_in = din; noise = nz;
        enc_result = e_res; enc_dly = e_dly;
        dec_result = d_res; dec_nerr = nerr; dec_dly = d_dly;
        exp_enc_word = x_enc; exp_dec_word = x_dec;
        enc_hi = 0; dec_hi = 0; done_before = done_cnt;
        e.data = x_data; e.nerr = x_nerr; e.err = x_err;
        sbq.push_back(e);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 0;
        forever begin
            @(negedge clk);
            if (lat == 0) chk("busy_after_start", 32'(busy), 32'd1);
            if (operation_done || lat >= 60) break;
            if (lat == 0 && dbl) begin
                // second start while busy, with different operands: must be ignored
                data_in = ~din; ctrl = 2'b01; noise = 32'hFFFF_FFFF; start = 1'b1;
                @(posedge clk);
                #1 start = 1'b0;
            end
            lat++;
        end
        chk("done_latency", 32'(lat), 32'(x_lat));
        @(negedge clk);
        chk("done_single_cycle", 32'(operation_done), 32'd0);
        chk("busy_idle", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        chk("done_count", 32'(done_cnt - done_before), 32'd1);
        chk("enc_req_cycles", 32'(enc_hi), 32'(x_enc_hi));
        chk("dec_req_cycles", 32'(dec_hi), 32'(x_dec_hi));
        if (!x_err) last_data = x_data;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int done_before;
        #12;
        chk("rst_data_out", data_out, 32'd0);
        chk("rst_nerr", 32'(num_of_errors), 32'd0);
        chk("rst_done", 32'(operation_done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_reqs", {30'd0, enc_req, dec_req}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;

        // encode, 8b codeword
        run_op(2'b00, 2'b00, 32'h5, 32'h0, 32'hFFFF_FFA5, 0, 32'h0, 2'd0, 0,
               32'h5, 32'h0, 32'h0000_00A5, 2'd0, 1'b0, 2, 1, 0, 1'b0);
        // full channel, 32b codeword
        run_op(2'b10, 2'b10, 32'h02AB_CDEF, 32'h1, 32'h1234_ABCD, 0, 32'h03AB_CDEF, 2'd1, 0,
               32'h02AB_CDEF, 32'h1234_ABCC, 32'h03AB_CDEF, 2'd1, 1'b0, 3, 1, 1, 1'b0);
        // illegal ctrl, then illegal width_sel
        run_op(2'b11, 2'b00, 32'hDEAD_BEEF, 32'h0, 32'h0, 0, 32'h0, 2'd0, 0,
               32'h0, 32'h0, last_data, 2'd3, 1'b1, 1, 0, 0, 1'b0);
        run_op(2'b00, 2'b11, 32'hDEAD_BEEF, 32'h0, 32'h0, 0, 32'h0, 2'd0, 0,
               32'h0, 32'h0, last_data, 2'd3, 1'b1, 1, 0, 0, 1'b0);
        // decode, 16b codeword
        run_op(2'b01, 2'b01, 32'hABCD_1234, 32'h0, 32'h0, 0, 32'h1234_5678, 2'd0, 0,
               32'h0, 32'h0000_1234, 32'h0000_0678, 2'd0, 1'b0, 2, 0, 1, 1'b0);
        // decode timeout: no ack
        run_op(2'b01, 2'b00, 32'h1FF, 32'h0, 32'h0, 0, 32'h0, 2'd0, 1000,
               32'h0, 32'h0000_00FF, last_data, 2'd3, 1'b1, 17, 0, 16, 1'b0);
        // decode with ack in the 16th request cycle: ack beats the timeout
        run_op(2'b01, 2'b01, 32'hFFFF_1234, 32'h0, 32'h0, 0, 32'h0000_FFFF, 2'd2, 15,
               32'h0, 32'h0000_1234, 32'h0000_07FF, 2'd2, 1'b0, 17, 0, 16, 1'b0);
        // full channel with a slow encoder, 8b codeword
        run_op(2'b10, 2'b00, 32'hF3, 32'hFF0F, 32'hAB, 2, 32'hFE, 2'd2, 0,
               32'h3, 32'hA4, 32'hE, 2'd2, 1'b0, 5, 3, 1, 1'b0);
        // start while busy is ignored
        run_op(2'b00, 2'b01, 32'h123, 32'h0, 32'hABCDE, 2, 32'h0, 2'd0, 0,
               32'h123, 32'h0, 32'h0000_BCDE, 2'd0, 1'b0, 4, 3, 0, 1'b1);
        // encode timeout
        run_op(2'b00, 2'b10, 32'h1, 32'h0, 32'h0, 1000, 32'h0, 2'd0, 0,
               32'h1, 32'h0, last_data, 2'd3, 1'b1, 17, 16, 0, 1'b0);

        // reset during DEC_REQ
        @(negedge clk);
        ctrl = 2'b01; width_sel = 2'b00; data_in = 32'h55; dec_dly = 1000;
        exp_dec_word = 32'h55; done_before = done_cnt;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_op_dec_req", 32'(dec_req), 32'd1);
        rstn = 1'b0;
        #1;
        chk("rst_mid_dec_req", 32'(dec_req), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_data_out", data_out, 32'd0);
        chk("rst_mid_nerr", 32'(num_of_errors), 32'd0);
        repeat (3) @(negedge clk);
        chk("rst_mid_no_done", 32'(done_cnt - done_before), 32'd0);
        rstn = 1'b1;
        last_data = '0;

        // normal encode after reset
        run_op(2'b00, 2'b00, 32'hA, 32'h0, 32'h3C, 0, 32'h0, 2'd0, 0,
               32'hA, 32'h0, 32'h3C, 2'd0, 1'b0, 2, 1, 0, 1'b0);
        chk("sb_drained", 32'(sbq.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
